inst_rom_ctrl: RTL and testbench

Instruction-memory responder for the fetch stage: it accepts the program counter and chip-enable from `pc_reg` and returns the addressed 32-bit instruction one cycle later. It also contains a boot loader port that fills the instruction store word by word, plus a small state machine that gates fetch service until a program image is loaded. It sits between `pc_reg` and the IF/ID pipeline register.

---
 rtl/inst_rom_ctrl_pkg.sv | 10 +
 rtl/inst_rom_ctrl_mem.sv | 21 ++
 rtl/inst_rom_ctrl.sv | 86 ++++++++
 tb/tb_inst_rom_ctrl.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/inst_rom_ctrl_pkg.sv
// inst_rom_ctrl_pkg: shared bus widths, constants and loader state encoding.
package inst_rom_ctrl_pkg;
  localparam int INST_ADDR_W = 32;
  localparam int INST_W = 32;
  localparam int INST_MEM_NUM_LOG2 = 10;
  localparam logic [INST_W-1:0] ZERO_WORD = '0;
  localparam logic CHIP_ENABLE = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  typedef enum logic [1:0] {S_EMPTY, S_LOAD, S_RUN} state_e;
endpackage

// File: rtl/inst_rom_ctrl_mem.sv
// inst_mem: 2^AW x 32 synchronous RAM, one write port and one registered read port.
module inst_mem
  import inst_rom_ctrl_pkg::*;
#(
  parameter int AW = INST_MEM_NUM_LOG2
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [INST_W-1:0] wdata,
  input  logic [AW-1:0]     raddr,
  output logic [INST_W-1:0] rdata
);
  logic [INST_W-1:0] mem [2**AW];
  logic [INST_W-1:0] rdata_q;
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata_q <= mem[raddr];
  end
  assign rdata = rdata_q;
endmodule

// File: rtl/inst_rom_ctrl.sv
// inst_rom_ctrl: fetch responder with boot loader; fetches are served only after an image is loaded.
module inst_rom_ctrl
  import inst_rom_ctrl_pkg::*;
#(
  parameter int DEPTH_LOG2 = INST_MEM_NUM_LOG2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   ce,
  input  logic [INST_ADDR_W-1:0] addr,
  output logic [INST_W-1:0]      inst,
  output logic                   inst_valid,
  output logic                   fault,
  input  logic                   ld_start,
  input  logic                   ld_valid,
  input  logic [INST_W-1:0]      ld_data,
  input  logic                   ld_last,
  output logic                   ld_ready,
  output logic                   ld_ovf,
  output logic                   running
);
  localparam logic [DEPTH_LOG2-1:0] LAST_IDX = '1;
  localparam logic [DEPTH_LOG2-1:0] W_ONE = {{(DEPTH_LOG2-1){1'b0}}, 1'b1};
  localparam logic [DEPTH_LOG2:0] L_ONE = {{DEPTH_LOG2{1'b0}}, 1'b1};
  state_e state_q, state_d;
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d, idx;
  logic [DEPTH_LOG2:0] len_q, len_d;
  logic ovf_q, ovf_d, ready_q, ready_d, run_q, run_d;
  logic valid_q, valid_d, fault_q, fault_d, hit_q, hit_d;
  logic accept, fetch, bad, fill_end;
  logic [INST_W-1:0] rdata;
  always_comb begin
    accept = ld_valid & (state_q == S_LOAD);
    fill_end = accept & (ld_last | (wptr_q == LAST_IDX));
    state_d = ld_start ? S_LOAD : fill_end ? S_RUN : state_q;
    wptr_d = ld_start ? '0 : accept ? wptr_q + W_ONE : wptr_q;
    len_d = ld_start ? '0 : accept ? {1'b0, wptr_q} + L_ONE : len_q;
    ovf_d = ld_start ? 1'b0 : (accept & (wptr_q == LAST_IDX) & ~ld_last) | ovf_q;
    ready_d = state_d == S_LOAD;
    run_d = state_d == S_RUN;
    // a reload request in the same cycle cancels any fetch
    fetch = (ce == CHIP_ENABLE) & (state_q == S_RUN) & ~ld_start;
    bad = (|addr[1:0]) | (|addr[INST_ADDR_W-1:DEPTH_LOG2+2]);
    idx = addr[DEPTH_LOG2+1:2];
    valid_d = fetch & ~bad;
    fault_d = fetch & bad;
    hit_d = fetch & ~bad & ({1'b0, idx} < len_q);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_EMPTY;
      wptr_q  <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b0;
      run_q   <= 1'b0;
      valid_q <= 1'b0;
      fault_q <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
      run_q   <= run_d;
      valid_q <= valid_d;
      fault_q <= fault_d;
      hit_q   <= hit_d;
    end
  end
  inst_mem #(.AW(DEPTH_LOG2)) u_mem (
    .clk  (clk),
    .we   (accept & ~ld_start),
    .waddr(wptr_q),
    .wdata(ld_data),
    .raddr(idx),
    .rdata(rdata)
  );
  assign inst = hit_q ? rdata : ZERO_WORD;
  assign inst_valid = valid_q;
  assign fault = fault_q;
  assign ld_ready = ready_q;
  assign ld_ovf = ovf_q;
  assign running = run_q;
endmodule

// File: tb/tb_inst_rom_ctrl.sv
// tb_inst_rom_ctrl: directed tests of load, fetch, fault decode, overflow, reload and async reset.
module tb_inst_rom_ctrl;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic ce = 1'b0;
  logic [31:0] addr = '0;
  logic [31:0] inst;
  logic inst_valid, fault;
  logic ld_start = 1'b0;
  logic ld_valid = 1'b0;
  logic [31:0] ld_data = '0;
  logic ld_last = 1'b0;
  logic ld_ready, ld_ovf, running;
  int n_cmp = 0;
  int n_bad = 0;
  inst_rom_ctrl dut (
    .clk(clk), .rst(rst), .ce(ce), .addr(addr), .inst(inst), .inst_valid(inst_valid),
    .fault(fault), .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
    .ld_last(ld_last), .ld_ready(ld_ready), .ld_ovf(ld_ovf), .running(running)
  );
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic start_load();
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
  endtask
  task automatic beat(input logic [31:0] d, input logic last);
    ld_valid = 1'b1;
    ld_data = d;
    ld_last = last;
    step();
    ld_valid = 1'b0;
    ld_last = 1'b0;
  endtask
  task automatic fetch(input string name, input logic [31:0] a, input logic [31:0] e_inst,
                       input logic e_valid, input logic e_fault);
    ce = 1'b1;
    addr = a;
    step();
    ce = 1'b0;
    n_cmp++;
    if (inst !== e_inst || inst_valid !== e_valid || fault !== e_fault) begin
      n_bad++;
      $display("FAIL %s: got inst=%h valid=%b fault=%b, want inst=%h valid=%b fault=%b",
               name, inst, inst_valid, fault, e_inst, e_valid, e_fault);
    end
  endtask
  task automatic test_reset();
    #2;
    n_cmp++;
    if ({inst, inst_valid, fault, ld_ready, ld_ovf, running} !== 37'd0) begin
      n_bad++;
      $display("FAIL reset_outputs: got inst=%h v=%b f=%b rdy=%b ovf=%b run=%b, want all 0",
               inst, inst_valid, fault, ld_ready, ld_ovf, running);
    end
    rst = 1'b1;
    step();
  endtask
  task automatic test_not_running();
    n_cmp++;
    if (ld_ready !== 1'b0) begin n_bad++; $display("FAIL ready_empty: got %b want 0", ld_ready); end
    fetch("fetch_empty", 32'h0, 32'h0, 1'b0, 1'b0);
    start_load();
    n_cmp++;
    if (ld_ready !== 1'b1) begin n_bad++; $display("FAIL ready_load: got %b want 1", ld_ready); end
    fetch("fetch_load", 32'h0, 32'h0, 1'b0, 1'b0);
  endtask
  task automatic test_load_fetch();
    beat(32'h11, 1'b0);
    beat(32'h22, 1'b0);
    ce = 1'b1;
    addr = 32'h0;
    ld_valid = 1'b1;
    ld_data = 32'h33;
    step();
    n_cmp++;
    if (inst !== 32'h0 || inst_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL fetch_during_beat: got inst=%h valid=%b want 0/0", inst, inst_valid);
    end
    ce = 1'b0;
    ld_valid = 1'b0;
    beat(32'h44, 1'b1);
    n_cmp++;
    if (running !== 1'b1 || ld_ready !== 1'b0 || ld_ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL run_after_last: got run=%b rdy=%b ovf=%b want 1/0/0", running, ld_ready, ld_ovf);
    end
    fetch("fetch_0", 32'h0, 32'h11, 1'b1, 1'b0);
    fetch("fetch_4", 32'h4, 32'h22, 1'b1, 1'b0);
    fetch("fetch_8", 32'h8, 32'h33, 1'b1, 1'b0);
    fetch("fetch_c", 32'hC, 32'h44, 1'b1, 1'b0);
    fetch("fetch_len", 32'h10, 32'h0, 1'b1, 1'b0);
    fetch("fetch_misalign", 32'h6, 32'h0, 1'b0, 1'b1);
    fetch("fetch_range", 32'h1000, 32'h0, 1'b0, 1'b1);
  endtask
  task automatic test_back_to_back();
    ce = 1'b1;
    addr = 32'h4;
    step();
    addr = 32'h8;
    n_cmp++;
    if (inst !== 32'h22 || inst_valid !== 1'b1) begin
      n_bad++; $display("FAIL b2b_first: got inst=%h v=%b want 22/1", inst, inst_valid);
    end
    step();
    ce = 1'b0;
    n_cmp++;
    if (inst !== 32'h33 || inst_valid !== 1'b1) begin
      n_bad++; $display("FAIL b2b_second: got inst=%h v=%b want 33/1", inst, inst_valid);
    end
    step();
    n_cmp++;
    if (inst !== 32'h0 || inst_valid !== 1'b0 || fault !== 1'b0) begin
      n_bad++; $display("FAIL ce_low: got inst=%h v=%b f=%b want 0/0/0", inst, inst_valid, fault);
    end
  endtask
  task automatic test_overflow();
    int acc = 0;
    start_load();
    for (int i = 0; i < 1024; i++) begin
      if (ld_ready === 1'b1) acc++;
      beat(32'h1000_0000 + i, 1'b0);
    end
    n_cmp++;
    if (acc !== 1024) begin n_bad++; $display("FAIL ovf_accepted: got %0d want 1024", acc); end
    n_cmp++;
    if (ld_ready !== 1'b0 || ld_ovf !== 1'b1 || running !== 1'b1) begin
      n_bad++;
      $display("FAIL ovf_flags: got rdy=%b ovf=%b run=%b want 0/1/1", ld_ready, ld_ovf, running);
    end
    beat(32'hDEAD_BEEF, 1'b0);
    fetch("ovf_top", 32'hFFC, 32'h1000_03FF, 1'b1, 1'b0);
    fetch("ovf_bottom", 32'h0, 32'h1000_0000, 1'b1, 1'b0);
  endtask
  task automatic test_reload();
    ce = 1'b1;
    addr = 32'h0;
    ld_start = 1'b1;
    step();
    ld_start = 1'b0;
    ce = 1'b0;
    n_cmp++;
    if (inst_valid !== 1'b0 || running !== 1'b0 || ld_ready !== 1'b1 || ld_ovf !== 1'b0) begin
      n_bad++;
      $display("FAIL start_wins: got v=%b run=%b rdy=%b ovf=%b want 0/0/1/0",
               inst_valid, running, ld_ready, ld_ovf);
    end
    beat(32'hAA, 1'b1);
    fetch("reload_0", 32'h0, 32'hAA, 1'b1, 1'b0);
    fetch("reload_4", 32'h4, 32'h0, 1'b1, 1'b0);
    fetch("reload_ffc", 32'hFFC, 32'h0, 1'b1, 1'b0);
  endtask
  task automatic test_async_reset();
    ce = 1'b1;
    addr = 32'h0;
    step();
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({inst, inst_valid, fault, ld_ready, ld_ovf, running} !== 37'd0) begin
      n_bad++;
      $display("FAIL reset_run: got inst=%h v=%b f=%b rdy=%b ovf=%b run=%b, want all 0",
               inst, inst_valid, fault, ld_ready, ld_ovf, running);
    end
    ce = 1'b0;
    step();
    rst = 1'b1;
    step();
    start_load();
    beat(32'h51, 1'b0);
    beat(32'h52, 1'b0);
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({inst, inst_valid, fault, ld_ready, ld_ovf, running} !== 37'd0) begin
      n_bad++;
      $display("FAIL reset_load: got inst=%h v=%b f=%b rdy=%b ovf=%b run=%b, want all 0",
               inst, inst_valid, fault, ld_ready, ld_ovf, running);
    end
    step();
    rst = 1'b1;
    step();
    fetch("post_reset_0", 32'h0, 32'h0, 1'b0, 1'b0);
    n_cmp++;
    if (ld_ready !== 1'b0 || running !== 1'b0) begin
      n_bad++; $display("FAIL post_reset_state: got rdy=%b run=%b want 0/0", ld_ready, running);
    end
    beat(32'h77, 1'b1);
    fetch("post_reset_beat", 32'h0, 32'h0, 1'b0, 1'b0);
    start_load();
    beat(32'h55, 1'b1);
    fetch("post_reset_load", 32'h0, 32'h55, 1'b1, 1'b0);
  endtask
  initial begin
    test_reset();
    test_not_running();
    test_load_fetch();
    test_back_to_back();
    test_overflow();
    test_reload();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
